load_store_unit: RTL and testbench

Memory-stage load/store unit that consumes the execute-stage outputs and performs the data-memory access for the instruction in flight. It drives a single-outstanding request/acknowledge data bus and generates byte strobes and replicated store data. It sign- or zero-extends load data and flags misaligned accesses. It asserts a busy signal that the hazard unit turns into a pipeline stall while a bus transaction is pending.

---
 rtl/load_store_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit. Issues one outstanding
// request on a req/ack data bus, builds byte strobes and lane-replicated
// store data, extends load data, and flags misaligned accesses. busy_out is
// high while a bus transaction is pending so the hazard unit can stall.
module load_store_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [1:0]  load_store_size_in,
    input  logic        load_signed_in,
    input  logic [31:0] address_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_address_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        stall,
    input  logic        invalidate,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy_out,
    output logic        valid_out,
    output logic [31:0] load_data_out,
    output logic [4:0]  rd_address_out,
    output logic        exception_out,
    output logic [3:0]  ecause_out
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_strb_q, mem_strb_d;
    logic        valid_q, valid_d;
    logic [31:0] load_data_q, load_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        exc_q, exc_d;
    logic [3:0]  ecause_q, ecause_d;
    // The pending access's shape is captured at accept time because the
    // upstream inputs are not held meaningful while we wait for the ack.
    logic        killed_q, killed_d;
    logic        ld_is_load_q, ld_is_load_d;
    logic        ld_signed_q, ld_signed_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic [1:0]  ld_off_q, ld_off_d;

    logic        mem_op;
    logic        misaligned;

    function automatic logic [3:0] make_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] make_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed lane out of the read word and sign/zero extend it.
    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] off, input logic [31:0] rdata);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = sgn ? 32'($signed(b)) : $signed({24'd0, b});
            2'b01:   r = sgn ? 32'($signed(h)) : $signed({16'd0, h});
            default: r = $signed(rdata);
        endcase
        return r;
    endfunction

    assign mem_op     = load_in | store_in;
    assign misaligned = (load_store_size_in == 2'b01 && address_in[0]) ||
                        (load_store_size_in[1] && address_in[1:0] != 2'b00);

    // Next-state and output-register logic for the IDLE/WAIT controller.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_strb_d   = mem_strb_q;
        valid_d      = valid_q;
        load_data_d  = load_data_q;
        rd_d         = rd_q;
        exc_d        = exc_q;
        ecause_d     = ecause_q;
        killed_d     = killed_q;
        ld_is_load_d = ld_is_load_q;
        ld_signed_d  = ld_signed_q;
        ld_size_d    = ld_size_q;
        ld_off_d     = ld_off_q;

        case (state_q)
            IDLE: begin
                if (!stall) begin
                    rd_d        = rd_address_in;
                    valid_d     = valid_in & ~invalidate;
                    mem_req_d   = 1'b0;
                    mem_strb_d  = 4'b0000;
                    killed_d    = 1'b0;
                    load_data_d = 32'd0;
                    exc_d       = 1'b0;
                    ecause_d    = 4'd0;
                    if (exception_in) begin
                        exc_d    = 1'b1;
                        ecause_d = ecause_in;
                    end else if (mem_op && misaligned) begin
                        exc_d    = 1'b1;
                        ecause_d = load_in ? ECAUSE_LOAD_MISALIGNED : ECAUSE_STORE_MISALIGNED;
                    end else if (mem_op && valid_in && !invalidate) begin
                        state_d      = WAIT;
                        valid_d      = 1'b0;
                        mem_req_d    = 1'b1;
                        mem_write_d  = store_in;
                        mem_addr_d   = {address_in[31:2], 2'b00};
                        mem_wdata_d  = make_wdata(load_store_size_in, store_data_in);
                        mem_strb_d   = store_in ? make_strb(load_store_size_in, address_in[1:0])
                                                : 4'b0000;
                        ld_is_load_d = load_in;
                        ld_signed_d  = load_signed_in;
                        ld_size_d    = load_store_size_in;
                        ld_off_d     = address_in[1:0];
                    end
                end
            end
            WAIT: begin
                // The bus cannot be cancelled; an invalidate only hides the result.
                if (invalidate) begin
                    killed_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_strb_d  = 4'b0000;
                    valid_d     = ~(killed_q | invalidate);
                    load_data_d = ld_is_load_q ? extend_load(ld_size_q, ld_signed_q, ld_off_q, mem_rdata)
                                               : 32'd0;
                    killed_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_strb_q   <= 4'b0000;
            valid_q      <= 1'b0;
            load_data_q  <= 32'd0;
            rd_q         <= 5'd0;
            exc_q        <= 1'b0;
            ecause_q     <= 4'd0;
            killed_q     <= 1'b0;
            ld_is_load_q <= 1'b0;
            ld_signed_q  <= 1'b0;
            ld_size_q    <= 2'b00;
            ld_off_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_strb_q   <= mem_strb_d;
            valid_q      <= valid_d;
            load_data_q  <= load_data_d;
            rd_q         <= rd_d;
            exc_q        <= exc_d;
            ecause_q     <= ecause_d;
            killed_q     <= killed_d;
            ld_is_load_q <= ld_is_load_d;
            ld_signed_q  <= ld_signed_d;
            ld_size_q    <= ld_size_d;
            ld_off_q     <= ld_off_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_strb       = mem_strb_q;
    assign busy_out       = (state_q == WAIT);
    assign valid_out      = valid_q;
    assign load_data_out  = load_data_q;
    assign rd_address_out = rd_q;
    assign exception_out  = exc_q;
    assign ecause_out     = ecause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench with a transaction-level reference model
// checked on every falling clock edge, plus literal expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        valid_in = 1'b0, load_in = 1'b0, store_in = 1'b0;
    logic [1:0]  load_store_size_in = 2'b00;
    logic        load_signed_in = 1'b0;
    logic [31:0] address_in = 32'd0, store_data_in = 32'd0;
    logic [4:0]  rd_address_in = 5'd0;
    logic        exception_in = 1'b0;
    logic [3:0]  ecause_in = 4'd0;
    logic        stall = 1'b0, invalidate = 1'b0;
    logic        mem_req, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy_out, valid_out;
    logic [31:0] load_data_out;
    logic [4:0]  rd_address_out;
    logic        exception_out;
    logic [3:0]  ecause_out;

    int checks = 0;
    int errors = 0;

    load_store_unit dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .load_in(load_in),
        .store_in(store_in), .load_store_size_in(load_store_size_in),
        .load_signed_in(load_signed_in), .address_in(address_in),
        .store_data_in(store_data_in), .rd_address_in(rd_address_in),
        .exception_in(exception_in), .ecause_in(ecause_in), .stall(stall),
        .invalidate(invalidate), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy_out(busy_out),
        .valid_out(valid_out), .load_data_out(load_data_out),
        .rd_address_out(rd_address_out), .exception_out(exception_out),
        .ecause_out(ecause_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        e_req = 1'b0, e_write = 1'b0, e_valid = 1'b0, e_exc = 1'b0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_ld = 32'd0;
    logic [3:0]  e_strb = 4'd0, e_ecause = 4'd0;
    logic [4:0]  e_rd = 5'd0;
    logic        pend = 1'b0, killed = 1'b0, p_load = 1'b0, p_signed = 1'b0;
    int          p_sz = 1;
    logic [31:0] p_addr = 32'd0;

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_extend(input int sz, input logic sg,
                                             input logic [31:0] addr, input logic [31:0] rd);
        int          off;
        logic [31:0] v, mask;
        off  = int'(addr % 4);
        off  = off - (off % sz);
        v    = rd >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (sg && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_req = 0; e_write = 0; e_valid = 0; e_exc = 0; e_addr = 0; e_wdata = 0;
            e_ld = 0; e_strb = 0; e_ecause = 0; e_rd = 0; pend = 0; killed = 0;
        end else if (pend) begin
            if (invalidate) killed = 1;
            if (mem_ack) begin
                pend    = 0;
                e_req   = 0;
                e_strb  = 0;
                e_valid = !killed;
                e_ld    = p_load ? m_extend(p_sz, p_signed, p_addr, mem_rdata) : 32'd0;
                killed  = 0;
            end
        end else if (!stall) begin
            int sz;
            sz       = size_bytes(load_store_size_in);
            e_rd     = rd_address_in;
            e_valid  = valid_in && !invalidate;
            e_ld     = 0;
            e_exc    = 0;
            e_ecause = 0;
            e_req    = 0;
            e_strb   = 0;
            if (exception_in) begin
                e_exc = 1; e_ecause = ecause_in;
            end else if ((load_in || store_in) && (address_in % sz != 0)) begin
                e_exc = 1; e_ecause = load_in ? 4'd4 : 4'd6;
            end else if ((load_in || store_in) && valid_in && !invalidate) begin
                pend     = 1;
                e_req    = 1;
                e_valid  = 0;
                e_write  = store_in;
                e_addr   = address_in & ~32'd3;
                e_strb   = store_in ? 4'(((1 << sz) - 1) << (address_in % 4)) : 4'd0;
                for (int i = 0; i < 4; i++)
                    e_wdata[8*i +: 8] = store_data_in[8*(i % sz) +: 8];
                p_load   = load_in;
                p_signed = load_signed_in;
                p_sz     = sz;
                p_addr   = address_in;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_strb", 32'(mem_strb), 32'(e_strb));
        chk("busy_out", 32'(busy_out), 32'(pend));
        chk("valid_out", 32'(valid_out), 32'(e_valid));
        chk("load_data_out", load_data_out, e_ld);
        chk("rd_address_out", 32'(rd_address_out), 32'(e_rd));
        chk("exception_out", 32'(exception_out), 32'(e_exc));
        chk("ecause_out", 32'(ecause_out), 32'(e_ecause));
        if (e_req) begin
            chk("mem_write", 32'(mem_write), 32'(e_write));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
        valid_in = v; load_in = ld; store_in = st; load_store_size_in = sz;
        load_signed_in = sg; address_in = a; store_data_in = d; rd_address_in = rd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555, 5'd31);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int vld_cnt;
        #1 reset_n = 1'b0;
        step();
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_busy", 32'(busy_out), 32'd0);
        chk("reset_valid", 32'(valid_out), 32'd0);
        chk("reset_ld", load_data_out, 32'd0);
        step();
        #2 reset_n = 1'b1;
        step();

        // Signed byte load at 0x1003, ack after one cycle.
        drive(1, 1, 0, 2'b00, 1, 32'h0000_1003, 32'd0, 5'd5);
        step();
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr", mem_addr, 32'h0000_1000);
        chk("t1_strb", 32'(mem_strb), 32'd0);
        chk("t1_write", 32'(mem_write), 32'd0);
        chk("t1_busy", 32'(busy_out), 32'd1);
        idle_in();
        mem_ack = 1; mem_rdata = 32'h80AA_BBCC;
        step();
        chk("t1_valid", 32'(valid_out), 32'd1);
        chk("t1_ld", load_data_out, 32'hFFFF_FF80);
        chk("t1_model_ld", e_ld, 32'hFFFF_FF80);
        chk("t1_rd", 32'(rd_address_out), 32'd5);
        mem_ack = 0;

        // Half store at 0x102.
        drive(1, 0, 1, 2'b01, 0, 32'h0000_0102, 32'h1234_ABCD, 5'd7);
        step();
        chk("t2_write", 32'(mem_write), 32'd1);
        chk("t2_addr", mem_addr, 32'h0000_0100);
        chk("t2_strb", 32'(mem_strb), 32'hC);
        chk("t2_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("t2_model_wdata", e_wdata, 32'hABCD_ABCD);
        idle_in();
        mem_ack = 1;
        step();
        chk("t2_valid", 32'(valid_out), 32'd1);
        chk("t2_ld", load_data_out, 32'd0);
        mem_ack = 0;

        // Byte store at offset 1.
        drive(1, 0, 1, 2'b00, 0, 32'h0000_0051, 32'h0000_00E7, 5'd1);
        step();
        chk("tb_strb", 32'(mem_strb), 32'h2);
        chk("tb_wdata", mem_wdata, 32'hE7E7_E7E7);
        idle_in();
        mem_ack = 1;
        step();
        mem_ack = 0;

        // Misaligned word load then store.
        drive(1, 1, 0, 2'b10, 0, 32'h0000_0101, 32'd0, 5'd3);
        step();
        chk("t3_req", 32'(mem_req), 32'd0);
        chk("t3_exc", 32'(exception_out), 32'd1);
        chk("t3_ecause", 32'(ecause_out), 32'd4);
        chk("t3_busy", 32'(busy_out), 32'd0);
        drive(1, 0, 1, 2'b10, 0, 32'h0000_0101, 32'd0, 5'd3);
        step();
        chk("t3s_ecause", 32'(ecause_out), 32'd6);
        chk("t3s_model_ecause", 32'(e_ecause), 32'd6);
        chk("t3s_req", 32'(mem_req), 32'd0);

        // Word load with three ack wait cycles.
        drive(1, 1, 0, 2'b10, 0, 32'h0000_0200, 32'd0, 5'd9);
        busy_cnt = 0;
        vld_cnt = 0;
        step();
        idle_in();
        if (busy_out) busy_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy_out) busy_cnt++;
            if (valid_out) vld_cnt++;
            chk("t4_addr_stable", mem_addr, 32'h0000_0200);
            chk("t4_req_stable", 32'(mem_req), 32'd1);
        end
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        if (valid_out) vld_cnt++;
        chk("t4_ld", load_data_out, 32'hDEAD_BEEF);
        mem_ack = 0;
        step();
        if (valid_out) vld_cnt++;
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("t4_valid_pulses", 32'(vld_cnt), 32'd1);

        // Load killed in WAIT; stall during WAIT must not block completion.
        drive(1, 1, 0, 2'b10, 0, 32'h0000_0300, 32'd0, 5'd11);
        step();
        idle_in();
        invalidate = 1;
        step();
        invalidate = 0; stall = 1; mem_ack = 1; mem_rdata = 32'h1111_1111;
        step();
        chk("t5_valid", 32'(valid_out), 32'd0);
        chk("t5_busy", 32'(busy_out), 32'd0);
        stall = 0; mem_ack = 0;
        step();

        // Asynchronous reset during WAIT, late ack ignored.
        drive(1, 1, 0, 2'b10, 0, 32'h0000_0400, 32'd0, 5'd2);
        step();
        idle_in();
        chk("t6_busy_before", 32'(busy_out), 32'd1);
        #2 reset_n = 0;
        #1;
        chk("t6_req_async", 32'(mem_req), 32'd0);
        chk("t6_busy_async", 32'(busy_out), 32'd0);
        chk("t6_valid_async", 32'(valid_out), 32'd0);
        chk("t6_model_busy", 32'(pend), 32'd0);
        mem_ack = 1;
        step();
        #2 reset_n = 1;
        step();
        chk("t6_late_ack", 32'(valid_out), 32'd0);
        mem_ack = 0;
        drive(1, 1, 0, 2'b01, 0, 32'h0000_0402, 32'd0, 5'd4);
        step();
        idle_in();
        mem_ack = 1; mem_rdata = 32'h8001_1234;
        step();
        chk("t6_uhalf", load_data_out, 32'h0000_8001);
        chk("t6_valid", 32'(valid_out), 32'd1);
        mem_ack = 0;
        drive(1, 1, 0, 2'b01, 1, 32'h0000_0400, 32'd0, 5'd4);
        step();
        idle_in();
        mem_ack = 1; mem_rdata = 32'h7FFF_8000;
        step();
        chk("t6_shalf", load_data_out, 32'hFFFF_8000);
        mem_ack = 0;

        // Non-memory instruction, then IDLE stall holds outputs.
        drive(1, 0, 0, 2'b10, 0, 32'h0000_0003, 32'd0, 5'd12);
        step();
        chk("t7_valid", 32'(valid_out), 32'd1);
        chk("t7_rd", 32'(rd_address_out), 32'd12);
        stall = 1;
        drive(0, 0, 0, 2'b00, 0, 32'd0, 32'd0, 5'd20);
        step();
        chk("t7_hold_rd", 32'(rd_address_out), 32'd12);
        chk("t7_hold_valid", 32'(valid_out), 32'd1);
        stall = 0;

        // Upstream exception passes through without a bus access.
        drive(1, 1, 0, 2'b10, 0, 32'h0000_0500, 32'd0, 5'd6);
        exception_in = 1; ecause_in = 4'hB;
        step();
        chk("t8_exc", 32'(exception_out), 32'd1);
        chk("t8_ecause", 32'(ecause_out), 32'hB);
        chk("t8_req", 32'(mem_req), 32'd0);
        exception_in = 0; ecause_in = 0;

        // Invalidated incoming load is dropped.
        drive(1, 1, 0, 2'b10, 0, 32'h0000_0600, 32'd0, 5'd8);
        invalidate = 1;
        step();
        chk("t9_valid", 32'(valid_out), 32'd0);
        chk("t9_req", 32'(mem_req), 32'd0);
        invalidate = 0;
        idle_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
